wb_mux_n: RTL and testbench

- Parametrised 1-master to NUM_SLAVES-slave Wishbone classic interconnect.
- Decodes the master address against per-slave base/mask pairs and registers the slave select.
- Forwards one transaction at a time to the selected slave and returns its ack or err.
- Answers unmapped addresses and hung slaves with a bus error. It sits between the serial-to-Wishbone bridge master and the peripheral slaves.

---
 rtl/wb_mux_n.sv | 203 ++++++++++++++++++++
 tb/tb_wb_mux_n.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mux_n.sv
// ---------------------------------------------------------------------------
// wb_mux_n -- 1-master to NUM_SLAVES-slave Wishbone classic interconnect.
//
// Decodes the master address against per-slave base/mask pairs (lowest index
// wins on overlap), registers the one-hot slave select together with the
// address/data/control, forwards a single transaction and returns the
// selected slave's ack or err to the master as a one-cycle pulse. Unmapped
// addresses are answered with a bus error.
//
// Optional feature macro: WB_MUX_TIMEOUT_EN
//   defined   : a transfer that sees no ack/err for TIMEOUT_CYCLES cycles in
//               ACTIVE is terminated with a bus error.
//   undefined : no timeout counter; ACTIVE waits for ack/err or master abort.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   wbm_*               master side (adr/dat/we/sel/stb/cyc in, dat/ack/err out)
//   wbs_adr_o/dat_o/we_o/sel_o   shared registered slave request signals
//   wbs_stb_o/cyc_o     per-slave strobe/cycle (one-hot while ACTIVE)
//   wbs_dat_i           packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wbs_ack_i/err_i     per-slave ack/err
// ---------------------------------------------------------------------------
module wb_mux_n #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDR =
        {32'h300, 32'h200, 32'h100, 32'h000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {4{32'hFFFF_FF00}},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_WIDTH-1:0]            wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]            wbm_dat_i,
    output logic [DATA_WIDTH-1:0]            wbm_dat_o,
    input  logic                             wbm_we_i,
    input  logic [DATA_WIDTH/8-1:0]          wbm_sel_i,
    input  logic                             wbm_stb_i,
    input  logic                             wbm_cyc_i,
    output logic                             wbm_ack_o,
    output logic                             wbm_err_o,
    output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
    output logic [DATA_WIDTH-1:0]            wbs_dat_o,
    output logic                             wbs_we_o,
    output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
    output logic [NUM_SLAVES-1:0]            wbs_stb_o,
    output logic [NUM_SLAVES-1:0]            wbs_cyc_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]            wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]            wbs_err_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_wdat;
    logic [DATA_WIDTH-1:0]   r_rdat;
    logic                    r_we;
    logic [SEL_WIDTH-1:0]    r_bsel;
    logic                    r_ack;
    logic                    r_err;

    logic [NUM_SLAVES-1:0]   w_match;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic [DATA_WIDTH-1:0]   w_sel_dat;
    logic                    w_sel_ack;
    logic                    w_sel_err;
    logic                    w_timeout;

    // Per-slave address decode.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign w_match[gi] =
                (((wbm_adr_i ^ SLAVE_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH])
                  & SLAVE_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) == '0);
        end
    endgenerate

    // Priority pick: scanning downward lets the lowest matching index win.
    always_comb begin
        w_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    // r_sel is one-hot (or zero), so an AND-OR mux is sufficient.
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) begin
                w_sel_dat = w_sel_dat | wbs_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_sel_ack = |(wbs_ack_i & r_sel);
    assign w_sel_err = |(wbs_err_i & r_sel);

`ifdef WB_MUX_TIMEOUT_EN
    logic [15:0] r_cnt;
    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rdat  <= '0;
            r_we    <= 1'b0;
            r_bsel  <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
`ifdef WB_MUX_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                    if (wbm_cyc_i && wbm_stb_i) begin
                        if (|w_match) begin
                            r_sel   <= w_onehot;
                            r_adr   <= wbm_adr_i;
                            r_wdat  <= wbm_dat_i;
                            r_we    <= wbm_we_i;
                            r_bsel  <= wbm_sel_i;
`ifdef WB_MUX_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                            r_state <= S_ACTIVE;
                        end else begin
                            // Unmapped: answer straight away with an error.
                            r_rdat  <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_ACTIVE: begin
`ifdef WB_MUX_TIMEOUT_EN
                    r_cnt <= r_cnt + 16'd1;
`endif
                    // Abort beats any response; err beats ack.
                    if (!wbm_cyc_i) begin
                        r_sel   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_sel_err || w_timeout) begin
                        r_sel   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else if (w_sel_ack) begin
                        r_sel   <= '0;
                        r_rdat  <= w_sel_dat;
                        r_ack   <= 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_sel   <= '0;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wbm_dat_o = r_rdat;
    assign wbm_ack_o = r_ack;
    assign wbm_err_o = r_err;
    assign wbs_adr_o = r_adr;
    assign wbs_dat_o = r_wdat;
    assign wbs_we_o  = r_we;
    assign wbs_sel_o = r_bsel;
    assign wbs_stb_o = r_sel;
    assign wbs_cyc_o = r_sel;

endmodule

// File: tb/tb_wb_mux_n.sv
// ---------------------------------------------------------------------------
// Testbench for wb_mux_n: table-driven single transfers plus hand-written
// sequences for timeout, master abort, reset mid-transfer and overlapping
// address decode (second instance with slave0 mask = 0).
// ---------------------------------------------------------------------------
module tb_wb_mux_n;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic         wbm_we_i, wbm_stb_i, wbm_cyc_i, wbm_ack_o, wbm_err_o;
    logic [3:0]   wbm_sel_i;
    logic [31:0]  wbs_adr_o, wbs_dat_o;
    logic         wbs_we_o;
    logic [3:0]   wbs_sel_o, wbs_stb_o, wbs_cyc_o, wbs_ack_i, wbs_err_i;
    logic [127:0] wbs_dat_i;

    // Overlap-config instance signals (shares master inputs and reset).
    logic [31:0]  ovl_dat_o, ovl_adr_o, ovl_wdat_o;
    logic         ovl_ack_o, ovl_err_o, ovl_we_o;
    logic [3:0]   ovl_sel_o, ovl_stb_o, ovl_cyc_o, ovl_ack_i, ovl_err_i;
    logic [127:0] ovl_dat_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_mux_n #(.TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_we_o(wbs_we_o),
        .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
    );

    wb_mux_n #(
        .TIMEOUT_CYCLES(8),
        .SLAVE_MASK({32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'h0000_0000})
    ) u_ovl (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(ovl_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(ovl_ack_o), .wbm_err_o(ovl_err_o),
        .wbs_adr_o(ovl_adr_o), .wbs_dat_o(ovl_wdat_o), .wbs_we_o(ovl_we_o),
        .wbs_sel_o(ovl_sel_o), .wbs_stb_o(ovl_stb_o), .wbs_cyc_o(ovl_cyc_o),
        .wbs_dat_i(ovl_dat_i), .wbs_ack_i(ovl_ack_i), .wbs_err_i(ovl_err_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        we;
        logic [3:0]  sel;
        logic [1:0]  rsp;      // bit0: selected slave acks, bit1: selected slave errs
        logic [31:0] rdat;
        logic [3:0]  exp_stb;  // 0 means unmapped
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] adr, input logic [31:0] wdat,
                         input logic we, input logic [3:0] sel);
        @(negedge clk);
        wbm_adr_i = adr;
        wbm_dat_i = wdat;
        wbm_we_i  = we;
        wbm_sel_i = sel;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic idle_bus;
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
        wbs_ack_i = '0;
        wbs_err_i = '0;
        wbs_dat_i = '0;
        ovl_ack_i = '0;
        ovl_err_i = '0;
        ovl_dat_i = '0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int idx;
        issue(v.adr, v.wdat, v.we, v.sel);
        @(posedge clk); #1;
        chk($sformatf("v%0d_stb", n), wbs_stb_o, v.exp_stb);
        chk($sformatf("v%0d_cyc", n), wbs_cyc_o, v.exp_stb);
        if (v.exp_stb != 4'd0) begin
            chk($sformatf("v%0d_req", n), {wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o},
                {v.adr, v.wdat, v.we, v.sel});
            idx = 0;
            for (int i = 0; i < 4; i++) if (v.exp_stb[i]) idx = i;
            // Non-selected slices / strobes carry decoy values that must be ignored.
            wbs_dat_i = {4{~v.rdat}};
            wbs_dat_i[idx*32 +: 32] = v.rdat;
            wbs_ack_i = v.rsp[0] ? v.exp_stb : ~v.exp_stb;
            wbs_err_i = v.rsp[1] ? v.exp_stb : ~v.exp_stb;
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_resp", n), {wbm_ack_o, wbm_err_o}, {v.exp_ack, v.exp_err});
        chk($sformatf("v%0d_stb_off", n), wbs_stb_o, 4'd0);
        if (v.chk_dat) chk($sformatf("v%0d_dat", n), wbm_dat_o, v.exp_dat);
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk($sformatf("v%0d_pulse", n), {wbm_ack_o, wbm_err_o}, 2'b00);
    endtask

    initial begin
        int cnt;
        vecs[0] = '{32'h0000_0104, 32'h0, 1'b0, 4'hF, 2'd1, 32'hDEAD_BEEF, 4'b0010, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0208, 32'h1234_5678, 1'b1, 4'hF, 2'd1, 32'h0, 4'b0100, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[2] = '{32'hFF00_0000, 32'h0, 1'b0, 4'hF, 2'd0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[3] = '{32'h0000_00FC, 32'h0, 1'b0, 4'h1, 2'd2, 32'h5555_AAAA, 4'b0001, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[4] = '{32'h0000_03F0, 32'h0, 1'b0, 4'hF, 2'd3, 32'h7777_7777, 4'b1000, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_0300, 32'h0, 1'b0, 4'hF, 2'd1, 32'hA5A5_0001, 4'b1000, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001};
        vecs[6] = '{32'h0000_01FF, 32'hCAFE_0011, 1'b1, 4'h3, 2'd1, 32'h0000_0011, 4'b0010, 1'b1, 1'b0, 1'b1, 32'h0000_0011};

        rst = 1'b1;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o},
            128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 7; n++) begin
            run_vec(n, vecs[n]);
            $display("vector %0d adr=%08h ack=%0b err=%0b dat=%08h", n, vecs[n].adr, wbm_ack_o, wbm_err_o, wbm_dat_o);
        end

        // Hung slave3.
        issue(32'h0000_0308, 32'h0, 1'b0, 4'hF);
        @(posedge clk); #1;
`ifdef WB_MUX_TIMEOUT_EN
        cnt = 0;
        for (int k = 0; k < 120 && wbs_stb_o[3]; k++) begin
            cnt++;
            @(posedge clk); #1;
        end
        chk("timeout_stb_cycles", cnt, 8);
        chk("timeout_err", {wbm_ack_o, wbm_err_o}, 2'b01);
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk("timeout_pulse", {wbm_ack_o, wbm_err_o}, 2'b00);
`else
        repeat (100) @(posedge clk);
        #1;
        chk("no_timeout_wait", {wbs_stb_o, wbm_ack_o, wbm_err_o}, {4'b1000, 2'b00});
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk("no_timeout_abort", {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o}, 10'd0);
`endif
        $display("timeout sequence done ack=%0b err=%0b", wbm_ack_o, wbm_err_o);

        // Master abort during ACTIVE.
        issue(32'h0000_0100, 32'h0, 1'b0, 4'hF);
        @(posedge clk); #1;
        chk("abort_stb", wbs_stb_o, 4'b0010);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk("abort_drop", {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o}, 10'd0);
        @(posedge clk); #1;
        chk("abort_no_resp", {wbm_ack_o, wbm_err_o}, 2'b00);
        $display("abort sequence done stb=%b", wbs_stb_o);

        // Reset during ACTIVE.
        issue(32'h0000_0200, 32'h0, 1'b0, 4'hF);
        @(posedge clk); #1;
        chk("rst_act_stb", wbs_stb_o, 4'b0100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_outputs",
            {wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_dat_o, wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o},
            128'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        @(posedge clk); #1;
        chk("rst_no_resp", {wbm_ack_o, wbm_err_o}, 2'b00);
        run_vec(7, vecs[0]);
        $display("reset sequence done, follow-up ack=%0b", wbm_ack_o);

        // Overlap decode: slave0 (mask 0) wins over slave1; err beats ack.
        issue(32'h0000_0100, 32'h0, 1'b0, 4'hF);
        @(posedge clk); #1;
        chk("ovl_stb", ovl_stb_o, 4'b0001);
        ovl_ack_i = 4'b0001;
        ovl_err_i = 4'b0001;
        @(posedge clk); #1;
        chk("ovl_resp", {ovl_ack_o, ovl_err_o}, 2'b01);
        @(negedge clk);
        idle_bus();
        @(posedge clk); #1;
        chk("ovl_pulse", {ovl_ack_o, ovl_err_o}, 2'b00);
        $display("overlap sequence done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
